// File: rtl/register_file_4bit.sv
// ---------------------------------------------------------------------------
// register_file_4bit
//
// Eight-entry, 4-bit register file with a four-bit status flag register. It
// feeds operands to an external function unit and writes back the selected
// result (function-unit output or memory read data).
//
// Configuration macro:
//   REG0_ZERO_EN  defined   -> R0 is hard-wired to zero; writes to R0 are
//                              discarded and reads of address 0 return 0.
//                 undefined -> R0 is an ordinary writable register.
//
// Ports:
//   clk          in   1  rising-edge clock for all state
//   rst_n        in   1  asynchronous active-low reset (clears R0..R7, flags)
//   DA           in   3  destination register address
//   AA           in   3  busA source register address
//   BA           in   3  busB source register address
//   RW           in   1  register write enable
//   MB           in   1  busB select: 0 = R[BA], 1 = constant_in
//   MD           in   1  busD select: 0 = F, 1 = data_in
//   constant_in  in   4  immediate operand
//   data_in      in   4  memory read data
//   F            in   4  function-unit result
//   V, C, N, Z   in   1  function-unit status bits
//   FL           in   1  flag register load enable
//   busA         out  4  operand A (R[AA])
//   busB         out  4  operand B (constant_in or R[BA])
//   address_out  out  4  memory address, equal to busA
//   data_out     out  4  memory write data, R[BA] regardless of MB
//   flags        out  4  registered status {V,C,N,Z}
// ---------------------------------------------------------------------------
module register_file_4bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] DA,
    input  logic [2:0] AA,
    input  logic [2:0] BA,
    input  logic       RW,
    input  logic       MB,
    input  logic       MD,
    input  logic [3:0] constant_in,
    input  logic [3:0] data_in,
    input  logic [3:0] F,
    input  logic       V,
    input  logic       C,
    input  logic       N,
    input  logic       Z,
    input  logic       FL,
    output logic [3:0] busA,
    output logic [3:0] busB,
    output logic [3:0] address_out,
    output logic [3:0] data_out,
    output logic [3:0] flags
);

    localparam int NUM_REGS = 8;

    // Current contents of every register, one element per generate slice.
    logic [3:0] reg_q [NUM_REGS];

    // One-hot write strobe per register.
    logic [NUM_REGS-1:0] wr_en;

    // Write-back data. Only consumed at the clock edge, so the read ports
    // never see it in the same cycle: no bypass path and no loop through
    // the function unit.
    logic [3:0] bus_d;

    logic [3:0] flags_reg;

    assign bus_d = MD ? data_in : F;

    // -----------------------------------------------------------------------
    // Register storage. Each register is a separate flop group because the
    // asynchronous clear rules out a memory macro.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            assign wr_en[gi] = RW && (DA == 3'(gi));

`ifdef REG0_ZERO_EN
            if (gi == 0) begin : g_zero
                // R0 is a constant; its write strobe is simply ignored.
                assign reg_q[gi] = 4'h0;
            end else begin : g_store
                logic [3:0] data_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        data_reg <= 4'h0;
                    end else if (wr_en[gi]) begin
                        data_reg <= bus_d;
                    end
                end

                assign reg_q[gi] = data_reg;
            end
`else
            begin : g_store
                logic [3:0] data_reg;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        data_reg <= 4'h0;
                    end else if (wr_en[gi]) begin
                        data_reg <= bus_d;
                    end
                end

                assign reg_q[gi] = data_reg;
            end
`endif
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Status flag register, loaded independently of the register write.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_reg <= 4'h0;
        end else if (FL) begin
            flags_reg <= {V, C, N, Z};
        end
    end

    // -----------------------------------------------------------------------
    // Combinational read ports. A read of the register being written this
    // cycle returns the pre-edge value.
    // -----------------------------------------------------------------------
    assign busA        = reg_q[AA];
    assign busB        = MB ? constant_in : reg_q[BA];
    assign address_out = busA;
    assign data_out    = reg_q[BA];
    assign flags       = flags_reg;

endmodule

// File: tb/tb_register_file_4bit.sv
// ---------------------------------------------------------------------------
// tb_register_file_4bit
//
// Directed self-checking bench for register_file_4bit. Each scenario task
// drives its own stimulus and compares outputs against hand-computed values.
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later,
// well away from the next edge. Build with +define+REG0_ZERO_EN to check the
// hard-wired R0 configuration.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_register_file_4bit;

    logic       clk;
    logic       rst_n;
    logic [2:0] DA, AA, BA;
    logic       RW, MB, MD;
    logic [3:0] constant_in, data_in, F;
    logic       V, C, N, Z, FL;
    logic [3:0] busA, busB, address_out, data_out, flags;

    int compared   = 0;
    int mismatched = 0;

`ifdef REG0_ZERO_EN
    localparam bit R0_ZERO = 1'b1;
`else
    localparam bit R0_ZERO = 1'b0;
`endif

    register_file_4bit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .DA          (DA),
        .AA          (AA),
        .BA          (BA),
        .RW          (RW),
        .MB          (MB),
        .MD          (MD),
        .constant_in (constant_in),
        .data_in     (data_in),
        .F           (F),
        .V           (V),
        .C           (C),
        .N           (N),
        .Z           (Z),
        .FL          (FL),
        .busA        (busA),
        .busB        (busB),
        .address_out (address_out),
        .data_out    (data_out),
        .flags       (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus helper: write one register from F over one edge.
    task automatic write_reg(input logic [2:0] addr, input logic [3:0] val);
        DA = addr; F = val; MD = 1'b0; RW = 1'b1;
        tick();
        RW = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        // Load something non-zero so the clear is observable.
        write_reg(3'd2, 4'h5);
        write_reg(3'd7, 4'hB);
        {V, C, N, Z} = 4'b1111; FL = 1'b1;
        tick();
        FL = 1'b0;
        // Assert reset mid-cycle with a write pending.
        DA = 3'd2; F = 4'h9; MD = 1'b0; RW = 1'b1; FL = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        MB = 1'b0;
        for (int i = 0; i < 8; i++) begin
            AA = 3'(i); BA = 3'(i);
            #1;
            compared++;
            if (busA !== 4'h0 || data_out !== 4'h0 || busB !== 4'h0) begin
                mismatched++;
                $display("FAIL reset_clear r%0d: busA=%h data_out=%h busB=%h required 0",
                         i, busA, data_out, busB);
            end
        end
        compared++;
        if (flags !== 4'h0) begin
            mismatched++;
            $display("FAIL reset_flags: flags=%b required 0000", flags);
        end
        MB = 1'b1; constant_in = 4'h6;
        #1;
        compared++;
        if (busB !== 4'h6) begin
            mismatched++;
            $display("FAIL reset_busb_const: busB=%h required 6", busB);
        end
        // An edge while in reset with RW/FL high must not write.
        @(posedge clk);
        #2 rst_n = 1'b1;
        RW = 1'b0; FL = 1'b0; MB = 1'b0; AA = 3'd2;
        #1;
        compared++;
        if (busA !== 4'h0 || flags !== 4'h0) begin
            mismatched++;
            $display("FAIL reset_write_lost: busA=%h flags=%b required 0/0000", busA, flags);
        end
        $display("test_reset done");
    endtask

    // -----------------------------------------------------------------------
    task automatic test_write_read();
        write_reg(3'd3, 4'hA);
        AA = 3'd3;
        #1;
        compared++;
        if (busA !== 4'hA || address_out !== 4'hA) begin
            mismatched++;
            $display("FAIL write_read: busA=%h address_out=%h required A/A", busA, address_out);
        end
        $display("test_write_read: busA=%h address_out=%h", busA, address_out);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_same_cycle();
        write_reg(3'd5, 4'h2);
        AA = 3'd5; DA = 3'd5; F = 4'h7; MD = 1'b0; RW = 1'b1;
        #1;
        compared++;
        if (busA !== 4'h2) begin
            mismatched++;
            $display("FAIL same_cycle_before: busA=%h required 2", busA);
        end
        tick();
        RW = 1'b0;
        compared++;
        if (busA !== 4'h7) begin
            mismatched++;
            $display("FAIL same_cycle_after: busA=%h required 7", busA);
        end
        // AA = BA = DA: both read ports return the old value, write lands.
        AA = 3'd5; BA = 3'd5; DA = 3'd5; MB = 1'b0; F = 4'h3; RW = 1'b1;
        #1;
        compared++;
        if (busA !== 4'h7 || busB !== 4'h7 || data_out !== 4'h7) begin
            mismatched++;
            $display("FAIL triple_same_before: busA=%h busB=%h data_out=%h required 7",
                     busA, busB, data_out);
        end
        tick();
        RW = 1'b0;
        compared++;
        if (busA !== 4'h3 || busB !== 4'h3) begin
            mismatched++;
            $display("FAIL triple_same_after: busA=%h busB=%h required 3", busA, busB);
        end
        $display("test_same_cycle: final busA=%h", busA);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_operand_select();
        write_reg(3'd6, 4'h9);
        BA = 3'd6; MB = 1'b1; constant_in = 4'h4;
        #1;
        compared++;
        if (busB !== 4'h4 || data_out !== 4'h9) begin
            mismatched++;
            $display("FAIL operand_const: busB=%h data_out=%h required 4/9", busB, data_out);
        end
        MB = 1'b0;
        #1;
        compared++;
        if (busB !== 4'h9) begin
            mismatched++;
            $display("FAIL operand_reg: busB=%h required 9", busB);
        end
        // Memory data path into R1; F carries a different value.
        DA = 3'd1; MD = 1'b1; data_in = 4'hC; F = 4'h1; RW = 1'b1;
        tick();
        RW = 1'b0; MD = 1'b0; AA = 3'd1;
        #1;
        compared++;
        if (busA !== 4'hC) begin
            mismatched++;
            $display("FAIL operand_md: R1=%h required C", busA);
        end
        $display("test_operand_select: R1=%h", busA);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_flags();
        {V, C, N, Z} = 4'b1010; FL = 1'b1;
        tick();
        FL = 1'b0;
        compared++;
        if (flags !== 4'b1010) begin
            mismatched++;
            $display("FAIL flags_load: flags=%b required 1010", flags);
        end
        {V, C, N, Z} = 4'b0101;
        tick();
        compared++;
        if (flags !== 4'b1010) begin
            mismatched++;
            $display("FAIL flags_hold: flags=%b required 1010", flags);
        end
        // Register write and flag load in the same cycle.
        {V, C, N, Z} = 4'b0011; FL = 1'b1;
        DA = 3'd4; F = 4'hB; MD = 1'b0; RW = 1'b1;
        tick();
        FL = 1'b0; RW = 1'b0; AA = 3'd4;
        #1;
        compared++;
        if (flags !== 4'b0011 || busA !== 4'hB) begin
            mismatched++;
            $display("FAIL flags_with_write: flags=%b R4=%h required 0011/B", flags, busA);
        end
        $display("test_flags: flags=%b", flags);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_r0();
        logic [3:0] exp_r0;
        exp_r0 = R0_ZERO ? 4'h0 : 4'hF;
        write_reg(3'd0, 4'hF);
        AA = 3'd0; BA = 3'd0; MB = 1'b0;
        #1;
        compared++;
        if (busA !== exp_r0 || data_out !== exp_r0) begin
            mismatched++;
            $display("FAIL r0_behaviour: busA=%h data_out=%h required %h",
                     busA, data_out, exp_r0);
        end
        $display("test_r0: busA=%h", busA);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [3:0] vals [8];
        vals = '{4'h8, 4'h3, 4'hE, 4'h5, 4'hA, 4'h6, 4'hD, 4'h1};
        MD = 1'b0; RW = 1'b1;
        for (int i = 0; i < 8; i++) begin
            DA = 3'(i); F = vals[i];
            tick();
        end
        RW = 1'b0; MB = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] exp;
            exp = (i == 0 && R0_ZERO) ? 4'h0 : vals[i];
            AA = 3'(i); BA = 3'(7 - i);
            #1;
            compared++;
            if (busA !== exp) begin
                mismatched++;
                $display("FAIL b2b_read r%0d: busA=%h required %h", i, busA, exp);
            end
        end
        // RW low: a pending DA/F must not disturb R3.
        DA = 3'd3; F = 4'h0; RW = 1'b0;
        tick();
        AA = 3'd3;
        #1;
        compared++;
        if (busA !== 4'h5) begin
            mismatched++;
            $display("FAIL rw_hold: R3=%h required 5", busA);
        end
        $display("test_back_to_back done");
    endtask

    // -----------------------------------------------------------------------
    initial begin
        rst_n = 1'b0;
        DA = '0; AA = '0; BA = '0;
        RW = 1'b0; MB = 1'b0; MD = 1'b0;
        constant_in = '0; data_in = '0; F = '0;
        V = 1'b0; C = 1'b0; N = 1'b0; Z = 1'b0; FL = 1'b0;
        #12 rst_n = 1'b1;
        tick();

        test_reset();
        test_write_read();
        test_same_cycle();
        test_operand_select();
        test_flags();
        test_r0();
        test_back_to_back();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
